// File: rtl/inv_delay_pkg.sv
// Shared types and reset defaults for the inverting delay controller.
package inv_delay_pkg;

  localparam int DW_DEF       = 4;
  localparam int CW_DEF       = 8;
  localparam int RISE_DLY_DEF = 3;
  localparam int FALL_DLY_DEF = 5;

  typedef enum logic [1:0] {
    STABLE_LO,
    STABLE_HI,
    RISE_PEND,
    FALL_PEND
  } state_t;

endpackage

// File: rtl/inv_dly_timer.sv
// Loadable down-counter; done flags the last cycle of a pending transition.
module inv_dly_timer #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  output logic          done
);

  logic [DW-1:0] cnt_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DW'(1);
    end
  end

  assign done = (cnt_q == DW'(1));

endmodule

// File: rtl/inv_delay_ctrl.sv
// Cycle-based inverter with separate rise/fall delays and inertial filtering.
// Optional rejected-pulse counter on glitch_cnt when INV_GLITCH_CNT_EN is defined.
module inv_delay_ctrl
  import inv_delay_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int RISE_DEF = RISE_DLY_DEF,
  parameter int FALL_DEF = FALL_DLY_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a,
  input  logic          cfg_valid,
  input  logic [DW-1:0] cfg_rise,
  input  logic [DW-1:0] cfg_fall,
  output logic          cfg_ready,
  output logic          y,
  output logic          busy
`ifdef INV_GLITCH_CNT_EN
  ,
  output logic [CW-1:0] glitch_cnt
`endif
);

  state_t        state_q, state_d;
  logic [DW-1:0] rise_q, fall_q;
  logic [DW-1:0] rise_eff, fall_eff;
  logic          target;
  logic          tmr_load, tmr_done;
  logic [DW-1:0] tmr_val;

  assign target   = ~a;
  assign rise_eff = (rise_q == '0) ? DW'(1) : rise_q;
  assign fall_eff = (fall_q == '0) ? DW'(1) : fall_q;

  // y is a pure decode of the registered state, so it changes only on edges.
  assign y         = (state_q == STABLE_HI) || (state_q == FALL_PEND);
  assign busy      = (state_q == RISE_PEND) || (state_q == FALL_PEND);
  assign cfg_ready = ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE_HI;
      rise_q  <= DW'(RISE_DEF);
      fall_q  <= DW'(FALL_DEF);
    end else begin
      state_q <= state_d;
      if (cfg_valid && cfg_ready) begin
        rise_q <= cfg_rise;
        fall_q <= cfg_fall;
      end
    end
  end

  // The detect edge already counts as the first delay cycle, so the timer is
  // loaded with D-1 and D=1 toggles y on the detect edge itself.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      STABLE_LO: if (target) begin
        if (rise_eff == DW'(1)) begin
          state_d = STABLE_HI;
        end else begin
          tmr_load = 1'b1;
          tmr_val  = rise_eff - DW'(1);
          state_d  = RISE_PEND;
        end
      end
      STABLE_HI: if (!target) begin
        if (fall_eff == DW'(1)) begin
          state_d = STABLE_LO;
        end else begin
          tmr_load = 1'b1;
          tmr_val  = fall_eff - DW'(1);
          state_d  = FALL_PEND;
        end
      end
      RISE_PEND: begin
        if (!target)       state_d = STABLE_LO;
        else if (tmr_done) state_d = STABLE_HI;
      end
      FALL_PEND: begin
        if (target)        state_d = STABLE_HI;
        else if (tmr_done) state_d = STABLE_LO;
      end
      default: state_d = STABLE_HI;
    endcase
  end

  inv_dly_timer #(.DW(DW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

`ifdef INV_GLITCH_CNT_EN
  logic cancel;

  // A pending transition whose target falls back to the current y is a reject.
  assign cancel = ((state_q == RISE_PEND) && !target) ||
                  ((state_q == FALL_PEND) &&  target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
    end else if (cancel && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_inv_delay_ctrl.sv
// Scoreboard bench for inv_delay_ctrl: a run-length reference model predicts y
// events, busy/cfg_ready and (with INV_GLITCH_CNT_EN) the reject count.
module tb_inv_delay_ctrl;

  localparam int DW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a;
  logic          cfg_valid;
  logic [DW-1:0] cfg_rise, cfg_fall;
  logic          cfg_ready, y, busy;
`ifdef INV_GLITCH_CNT_EN
  logic [CW-1:0] glitch_cnt;
`endif

  always #5 clk = ~clk;

  inv_delay_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .cfg_valid (cfg_valid),
    .cfg_rise  (cfg_rise),
    .cfg_fall  (cfg_fall),
    .cfg_ready (cfg_ready),
    .y         (y),
    .busy      (busy)
`ifdef INV_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  typedef struct {
    int   edge_no;
    logic val;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_no = 0;

  // Reference model: y flips once ~a has differed from y for D consecutive
  // sampled edges, D taken from the delays in force when that run began.
  logic ym;
  int   run, dcap, rise_m, fall_m, glitch_m;
  bit   last_acc;
  logic y_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    ym       = 1'b1;
    run      = 0;
    dcap     = 0;
    rise_m   = 3;
    fall_m   = 5;
    glitch_m = 0;
    last_acc = 1'b0;
  endtask

  task automatic model_edge();
    logic tgt;
    bit   acc;
    tgt = ~a;
    acc = cfg_valid && (run == 0);
    if (tgt != ym) begin
      if (run == 0) dcap = tgt ? eff(rise_m) : eff(fall_m);
      run++;
      if (run >= dcap) begin
        ym  = tgt;
        run = 0;
        exp_q.push_back('{edge_no, tgt});
      end
    end else begin
      if (run > 0 && glitch_m < 255) glitch_m++;
      run = 0;
    end
    if (acc) begin
      rise_m = int'(cfg_rise);
      fall_m = int'(cfg_fall);
    end
    last_acc = acc;
  endtask

  task automatic step();
    @(posedge clk);
    edge_no++;
    model_edge();
    #1;
  endtask

  task automatic hold(input logic a_v, input int n);
    a = a_v;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic offer_cfg(input logic a_v, input int r, input int f);
    int guard;
    a         = a_v;
    cfg_valid = 1'b1;
    cfg_rise  = DW'(r);
    cfg_fall  = DW'(f);
    guard     = 0;
    do begin
      step();
      guard++;
    end while (!last_acc && guard < 50);
    check("cfg_accept_timeout", last_acc, 1);
    cfg_valid = 1'b0;
  endtask

  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_y", y, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_ready, 1);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: per-cycle status compare plus a pop for every y change.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        y_prev = y;
        continue;
      end
      check("busy", busy, run > 0);
      check("cfg_ready", cfg_ready, run == 0);
`ifdef INV_GLITCH_CNT_EN
      check("glitch_cnt", glitch_cnt, glitch_m);
`endif
      if (y !== y_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL y_spurious: y went to %0b with no expected event (edge %0d)", y, edge_no);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("y_value", y, e.val);
          check("y_edge", edge_no, e.edge_no);
        end
        y_prev = y;
      end
      while (exp_q.size() > 0 && exp_q[0].edge_no < edge_no) begin
        ev_t m;
        m = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL y_missed: y=%0b expected %0b at edge %0d", y, m.val, m.edge_no);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    a         = 1'b0;
    cfg_valid = 1'b0;
    cfg_rise  = '0;
    cfg_fall  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_y", y, 1);
    check("reset_busy", busy, 0);
    check("reset_ready", cfg_ready, 1);
`ifdef INV_GLITCH_CNT_EN
    check("reset_glitch", glitch_cnt, 0);
`endif
    #3;
    rst_n = 1'b1;

    // Default delays: fall after 5, rise after 3, short pulse rejected.
    hold(1'b0, 3);
    hold(1'b1, 8);
    hold(1'b0, 6);
    hold(1'b1, 2);
    hold(1'b0, 6);

    // Zero and one delays: single-cycle pulses pass straight through.
    offer_cfg(1'b0, 0, 1);
    hold(1'b1, 1);
    hold(1'b0, 1);
    hold(1'b1, 2);
    hold(1'b0, 1);
    hold(1'b1, 1);
    hold(1'b0, 3);

    // Accept and detect on the same edge: old fall, then new rise/fall.
    offer_cfg(1'b0, 3, 5);
    hold(1'b0, 2);
    offer_cfg(1'b1, 2, 6);
    hold(1'b1, 8);
    hold(1'b0, 5);
    hold(1'b1, 9);
    hold(1'b0, 4);

    // Reset during a pending fall, then defaults must apply again.
    hold(1'b1, 2);
    async_reset();
    hold(1'b1, 8);
    hold(1'b0, 1);
    async_reset();
    hold(1'b0, 4);

    // Randomised stimulus with occasional reconfiguration.
    for (int i = 0; i < 800; i++) begin
      if (!cfg_valid && $urandom_range(0, 19) == 0) begin
        cfg_valid = 1'b1;
        cfg_rise  = DW'($urandom_range(0, 6));
        cfg_fall  = DW'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 3) == 0) a = ~a;
      step();
      if (last_acc) cfg_valid = 1'b0;
    end
    cfg_valid = 1'b0;
    hold(a, 20);

    #6;
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
